// File: rtl/somador_pkg.sv
// Shared constants and helpers for the pipelined wide adder/subtractor.
// Op encoding, chunk sizing and the signed limits used by the SOMADOR_SATURATE_EN clamp.
package somador_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits resolved per pipeline stage; a zero stage count falls back to a single chunk.
  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  // Limits are built in 64 bits and truncated by the caller, so WIDTH is bounded to 64.
  function automatic logic [63:0] signed_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] signed_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/somador_if.sv
// Operand/result bus of somador_pipeline: upstream beat, downstream result and flags.
interface somador_if #(
  parameter int WIDTH = 44
);

  // Valid/ready: a beat transfers on a rising edge where valid && ready. The producer
  // holds valid and its data stable until it transfers; ready may depend on valid
  // combinationally, and valid must never depend on ready.
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

endinterface

// File: rtl/somador_fatia.sv
// One pipeline slice: CHUNK-bit add with carry-in, registering sum chunk and carry-out.
module somador_fatia #(
  parameter int CHUNK = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= total[CHUNK-1:0];
      cout <= total[CHUNK];
    end
  end

endmodule

// File: rtl/somador_pipeline.sv
// WIDTH-bit add/subtract split into STAGES carry-chained slices with a global stall.
// Define SOMADOR_SATURATE_EN to clamp s to the signed limit on overflow.
module somador_pipeline
  import somador_pkg::*;
#(
  parameter int WIDTH  = 44,
  parameter int STAGES = 4
) (
  input  logic    clock,
  input  logic    reset,
  somador_if.slave bus
);

  localparam int CHUNK       = chunk_width(WIDTH, STAGES);
  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_cfg
    $error("somador_pipeline: STAGES=%0d must divide WIDTH=%0d", STAGES, WIDTH);
  end

  logic             stall;
  logic             adv;
  logic             sub;
  logic [WIDTH-1:0] b_aligned;

  // Subtract is x + ~y + 1; the +1 rides in as carry-in of chunk 0.
  assign sub       = (bus.op == OP_SUB);
  assign b_aligned = sub ? ~bus.y : bus.y;

  // A result held at the output freezes every stage, so nothing in flight is overwritten.
  assign stall        = g_stage[STAGES-1].v_q && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed when entering stage k.
    localparam int CW = WIDTH - k * CHUNK;

    logic [CW-1:0]          a_cur;
    logic [CW-1:0]          b_cur;
    logic                   cin;
    logic                   v_in;
    logic                   v_q;
    logic                   c_k;
    logic [CHUNK-1:0]       sum_k;
    logic [(k+1)*CHUNK-1:0] res;

    if (k == 0) begin : g_head
      assign a_cur = bus.x;
      assign b_cur = b_aligned;
      assign cin   = sub;
      assign v_in  = bus.in_valid;
    end else begin : g_body
      assign a_cur = g_stage[k-1].g_pass.a_hi;
      assign b_cur = g_stage[k-1].g_pass.b_hi;
      assign cin   = g_stage[k-1].c_k;
      assign v_in  = g_stage[k-1].v_q;
    end

    somador_fatia #(.CHUNK(CHUNK)) u_fatia (
      .clock (clock),
      .reset (reset),
      .en    (adv),
      .a     (a_cur[CHUNK-1:0]),
      .b     (b_cur[CHUNK-1:0]),
      .cin   (cin),
      .sum   (sum_k),
      .cout  (c_k)
    );

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_pass
      logic [CW-CHUNK-1:0] a_hi;
      logic [CW-CHUNK-1:0] b_hi;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_hi <= '0;
          b_hi <= '0;
        end else if (adv) begin
          a_hi <= a_cur[CW-1:CHUNK];
          b_hi <= b_cur[CW-1:CHUNK];
        end
      end
    end else begin : g_last
      // Only the operand sign bits survive into the final stage, for the overflow flag.
      logic a_msb;
      logic b_msb;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_msb <= 1'b0;
          b_msb <= 1'b0;
        end else if (adv) begin
          a_msb <= a_cur[CW-1];
          b_msb <= b_cur[CW-1];
        end
      end
    end

    if (k == 0) begin : g_res0
      assign res = sum_k;
    end else begin : g_low
      logic [k*CHUNK-1:0] low_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          low_q <= '0;
        end else if (adv) begin
          low_q <= g_stage[k-1].res;
        end
      end

      assign res = {sum_k, low_q};
    end
  end

  logic [WIDTH-1:0] s_raw;
  logic             a_msb;
  logic             b_msb;
  logic             ovf_w;

  assign s_raw = g_stage[STAGES-1].res;
  assign a_msb = g_stage[STAGES-1].g_last.a_msb;
  assign b_msb = g_stage[STAGES-1].g_last.b_msb;
  assign ovf_w = (a_msb == b_msb) && (s_raw[WIDTH-1] != a_msb);

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.cout      = g_stage[STAGES-1].c_k;
  assign bus.ovf       = ovf_w;

`ifdef SOMADOR_SATURATE_EN
  assign bus.s = !ovf_w ? s_raw :
                 a_msb  ? WIDTH'(signed_min(WIDTH)) : WIDTH'(signed_max(WIDTH));
`else
  assign bus.s = s_raw;
`endif

endmodule
